// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller: issues a one-cycle core clock enable from a programmable
// prescaler, a debounced step button and (with CPU_RUN_CTRL_BP_EN defined) PC breakpoints.
module cpu_run_ctrl #(
    parameter int CNT_W     = 32,
    parameter int ADDR_W    = 32,
    parameter int NUM_BP    = 2,
    parameter int DB_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [4:0]               div_sel,
    input  logic                     mode_run,
    input  logic                     halt_req,
    input  logic                     step_btn,
    input  logic [ADDR_W-1:0]        pc_i,
    input  logic [NUM_BP*ADDR_W-1:0] bp_addr_i,
    input  logic [NUM_BP-1:0]        bp_en_i,
    output logic                     cpu_ce_o,
    output logic [1:0]               state_o,
    output logic [NUM_BP-1:0]        bp_hit_o,
    output logic [15:0]              step_cnt_o
);

    localparam int              DB_W    = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        BRK  = 2'b11
    } state_t;

    state_t           state, stateNext;
    logic             ceNext;
    logic [CNT_W-1:0] preCnt, tickMask;
    logic             tick;
    logic             stepSync_p0, stepSync_p1;
    logic             dbLevel, dbLevelDly, stepP;
    logic [DB_W-1:0]  dbCnt;
    logic             bpMatch;
    logic [15:0]      stepCnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) preCnt <= '0;
        else       preCnt <= preCnt + CNT_W'(1);
    end

    // div_sel at or above CNT_W masks every bit, giving the longest period 2^CNT_W
    always_comb begin
        tickMask = '0;
        for (int i = 0; i < CNT_W; i++) tickMask[i] = (i < int'(div_sel));
    end

    assign tick = &(preCnt | ~tickMask);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stepSync_p0 <= 1'b0;
            stepSync_p1 <= 1'b0;
            dbLevel     <= 1'b0;
            dbLevelDly  <= 1'b0;
            dbCnt       <= '0;
        end else begin
            stepSync_p0 <= step_btn;
            stepSync_p1 <= stepSync_p0;
            dbLevelDly  <= dbLevel;
            if (stepSync_p1 == dbLevel) begin
                dbCnt <= '0;
            end else if (dbCnt == DB_LAST) begin
                dbLevel <= stepSync_p1;
                dbCnt   <= '0;
            end else begin
                dbCnt <= dbCnt + DB_W'(1);
            end
        end
    end

    assign stepP = dbLevel & ~dbLevelDly;

`ifdef CPU_RUN_CTRL_BP_EN
    logic [NUM_BP-1:0] bpVec;
    logic [NUM_BP-1:0] bpHit;

    // pc_i must already reflect the previous ce when the tick is evaluated
    always_comb begin
        bpVec = '0;
        for (int k = 0; k < NUM_BP; k++)
            bpVec[k] = bp_en_i[k] && (pc_i == bp_addr_i[k*ADDR_W +: ADDR_W]);
    end

    assign bpMatch = |bpVec;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                            bpHit <= '0;
        else if (state != BRK && stateNext == BRK) bpHit <= bpVec;
        else if (state == BRK && stateNext != BRK) bpHit <= '0;
    end

    assign bp_hit_o = bpHit;
`else
    logic unusedBp;

    assign unusedBp = ^{pc_i, bp_addr_i, bp_en_i};
    assign bpMatch  = 1'b0;
    assign bp_hit_o = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= HALT;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            HALT: begin
                if (mode_run && !halt_req) stateNext = RUN;
                else if (stepP)            stateNext = STEP;
            end
            RUN: begin
                if (halt_req || !mode_run) stateNext = HALT;
                else if (tick && bpMatch)  stateNext = BRK;
            end
            STEP: begin
                if (halt_req)  stateNext = HALT;
                else if (tick) stateNext = mode_run ? RUN : HALT;
            end
            BRK: begin
                if (halt_req)       stateNext = BRK;
                else if (!mode_run) stateNext = HALT;
                else if (stepP)     stateNext = STEP;
            end
        endcase
    end

    always_comb begin
        ceNext = 1'b0;
        unique case (state)
            RUN:     ceNext = tick && mode_run && !halt_req && !bpMatch;
            STEP:    ceNext = tick && !halt_req;
            default: ceNext = 1'b0;
        endcase
    end

    // the counter advances on the same edge the pulse rises, so it already includes it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_ce_o <= 1'b0;
            stepCnt  <= '0;
        end else begin
            cpu_ce_o <= ceNext;
            if (ceNext) stepCnt <= stepCnt + 16'd1;
        end
    end

    assign state_o    = state;
    assign step_cnt_o = stepCnt;

endmodule
